// File: rtl/bch63_pkg.sv
// bch63_pkg: GF(2^6) arithmetic, code constants and FSM types shared by the BCH(63,51) decoder.
package bch63_pkg;
    localparam int N = 63;
    localparam int K = 51;
    localparam logic [6:0] PRIM_POLY = 7'b100_0011;
    localparam logic [5:0] ALPHA  = 6'b00_0010;
    localparam logic [5:0] ALPHA2 = 6'b00_0100;
    localparam logic [5:0] ALPHA3 = 6'b00_1000;
    typedef enum logic [1:0] {RECV, CALC, SEND} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE, ERR_UNCORR} err_t;
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 6; i++) begin
            p ^= b[i] ? x : 6'd0;
            x = {x[4:0], 1'b0} ^ (x[5] ? PRIM_POLY[5:0] : 6'd0);
        end
        return p;
    endfunction
    function automatic logic [5:0] gf_cube(input logic [5:0] a);
        return gf_mul(gf_mul(a, a), a);
    endfunction
endpackage

// File: rtl/bch_dec_63_51_gf64_mul.sv
// gf64_mul: combinational general multiplier over GF(2^6) modulo x^6+x+1.
module gf64_mul
    import bch63_pkg::*;
(
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] p
);
    assign p = gf_mul(a, b);
endmodule

// File: rtl/bch_dec_63_51.sv
// bch_dec_63_51: serial two-error-correcting BCH(63,51) decoder, MSB first in and out.
// Define BCH_DEC_UNCORR_FLAG_EN to add the out_uncorr status port.
module bch_dec_63_51
    import bch63_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic out_valid,
    output logic out_data,
    input  logic out_ready
`ifdef BCH_DEC_UNCORR_FLAG_EN
    ,
    output logic out_uncorr
`endif
);
    state_t state, state_n;
    err_t ecls;
    logic [62:0] sreg;
    logic [5:0] cnt, s1, s3, t1, t2, sq, cube, d;
    logic last, acc, xfer, load, flip, done;

    gf64_mul u_sq   (.a(s1), .b(s1), .p(sq));
    gf64_mul u_cube (.a(sq), .b(s1), .p(cube));
    assign d = s3 ^ cube;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= RECV;
        else     state <= state_n;

    always_comb begin
        state_n = (state == RECV && acc && cnt == 6'(N - 1)) ? CALC :
                  (state == CALC)                             ? SEND :
                  (state == SEND && done)                     ? RECV : state;
    end

    // Output bits are produced into a register one step ahead of the
    // handshake, so out_data stays put while the receiver stalls.
    always_comb begin
        acc  = in_valid & in_ready;
        xfer = out_valid & out_ready;
        load = (state == SEND) & ~last & (~out_valid | out_ready);
        done = xfer & last;
        flip = (ecls == ERR_SINGLE || ecls == ERR_DOUBLE) && (s1 ^ t1 ^ t2) == 6'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            cnt       <= '0;
            sreg      <= '0;
            s1        <= '0;
            s3        <= '0;
            t1        <= '0;
            t2        <= '0;
            ecls      <= ERR_NONE;
            last      <= 1'b0;
        end else begin
            in_ready <= state_n == RECV;
            if (acc || load) cnt <= (cnt == 6'(N - 1)) ? 6'd0 : cnt + 6'd1;
            if (acc) begin
                sreg <= {sreg[61:0], in_data};
                s1   <= gf_mul(s1, ALPHA) ^ {5'd0, in_data};
                s3   <= gf_mul(s3, ALPHA3) ^ {5'd0, in_data};
            end
            if (state == CALC) begin
                ecls <= (s1 == 6'd0) ? ((s3 == 6'd0) ? ERR_NONE : ERR_UNCORR) :
                        (d == 6'd0)  ? ERR_SINGLE : ERR_DOUBLE;
                t1   <= gf_mul(sq, ALPHA);
                t2   <= gf_mul(d, ALPHA2);
            end
            if (load) begin
                out_data  <= sreg[62] ^ flip;
                out_valid <= 1'b1;
                sreg      <= {sreg[61:0], 1'b0};
                t1        <= gf_mul(t1, ALPHA);
                t2        <= gf_mul(t2, ALPHA2);
                last      <= cnt == 6'(N - 1);
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (done) begin
                s1   <= '0;
                s3   <= '0;
                last <= 1'b0;
            end
        end
    end

`ifdef BCH_DEC_UNCORR_FLAG_EN
    assign out_uncorr = (state == SEND) && (ecls == ERR_UNCORR);
`endif
endmodule

// File: tb/tb_bch_dec_63_51.sv
// tb_bch_dec_63_51: directed and randomised-error checks of the BCH(63,51) serial decoder.
module tb_bch_dec_63_51;
    import bch63_pkg::*;

    localparam logic [62:0] CW_SPEC = 63'h4257_B434_12D5_6C06;
    localparam logic [12:0] GPOLY   = 13'h1539;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_data = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_data;
`ifdef BCH_DEC_UNCORR_FLAG_EN
    logic out_uncorr;
`endif
    int n_pass = 0, n_chk = 0, overlap = 0;

    always #5 clk = ~clk;

    bch_dec_63_51 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef BCH_DEC_UNCORR_FLAG_EN
        , .out_uncorr(out_uncorr)
`endif
    );

    always @(negedge clk) if (in_ready && out_valid) overlap++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [62:0] enc(input logic [50:0] m);
        logic [62:0] r, c;
        r = {m, 12'd0};
        c = r;
        for (int i = 62; i >= N - K; i--)
            if (r[i]) r ^= {50'd0, GPOLY} << (i - (N - K));
        return c | r;
    endfunction

    task automatic feed(input logic [62:0] rx, input int nbits, input bit gaps);
        for (int i = 62; i > 62 - nbits; i--) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = rx[i];
            for (int t = 0; !in_ready && t < 300; t++) @(negedge clk);
            if (!in_ready) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit stalls, output logic [62:0] got, output int cnt,
                           output int lat, output bit uc);
        got = '0;
        cnt = 0;
        lat = 0;
        uc  = 1'b1;
        out_ready = 1'b1;
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        for (int t = 0; cnt < 63 && t < 3000; t++) begin
            out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                got[62 - cnt] = out_data;
                cnt++;
`ifdef BCH_DEC_UNCORR_FLAG_EN
                uc &= out_uncorr;
`endif
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    task automatic run(input string tag, input logic [62:0] rx, input logic [62:0] exp, input bit rnd);
        logic [62:0] got;
        int cnt, lat;
        bit uc;
        feed(rx, 63, rnd);
        collect(rnd, got, cnt, lat, uc);
        check({tag, "_data"}, {1'b0, got}, {1'b0, exp});
        check({tag, "_count"}, 64'(cnt), 64'd63);
    endtask

    initial begin
        logic [62:0] cw0, rx, got, cw;
        logic [50:0] msg;
        int cnt, lat, p1, p2, ne;
        bit uc;
        msg = CW_SPEC[62:12];
        cw0 = enc(msg);

        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {63'd0, out_data}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("in_ready_before_edge", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("in_ready_after_edge", {63'd0, in_ready}, 64'd1);

        feed(cw0, 63, 1'b0);
        collect(1'b0, got, cnt, lat, uc);
        check("clean_data", {1'b0, got}, {1'b0, cw0});
        check("clean_count", 64'(cnt), 64'd63);
        check("clean_latency", 64'(lat), 64'd2);
        check("clean_tail_valid", {63'd0, out_valid}, 64'd0);
        check("clean_tail_ready", {63'd0, in_ready}, 64'd1);
`ifdef BCH_DEC_UNCORR_FLAG_EN
        check("clean_uncorr", {63'd0, uc}, 64'd0);
`endif

        run("err_15_58", cw0 ^ (63'd1 << 15) ^ (63'd1 << 58), cw0, 1'b0);
        run("err_0", cw0 ^ 63'd1, cw0, 1'b0);
        run("err_62", cw0 ^ (63'd1 << 62), cw0, 1'b0);

        feed(cw0 ^ 63'h0E, 63, 1'b0);
        collect(1'b0, got, cnt, lat, uc);
        check("triple_count", 64'(cnt), 64'd63);
        check("triple_tail_valid", {63'd0, out_valid}, 64'd0);

        // errors at x^0, x^1, x^6 cancel in S1 but not in S3
        rx = cw0 ^ 63'h43;
        feed(rx, 63, 1'b0);
        collect(1'b0, got, cnt, lat, uc);
        check("uncorr_passthru", {1'b0, got}, {1'b0, rx});
`ifdef BCH_DEC_UNCORR_FLAG_EN
        check("uncorr_flag", {63'd0, uc}, 64'd1);
`endif

        for (int b = 0; b < 100; b++) begin
            msg = 51'({$urandom(), $urandom()});
            cw  = enc(msg);
            ne  = $urandom_range(0, 2);
            p1  = $urandom_range(0, 62);
            p2  = $urandom_range(0, 62);
            while (p2 == p1) p2 = $urandom_range(0, 62);
            rx = cw ^ ((ne >= 1) ? (63'd1 << p1) : 63'd0) ^ ((ne == 2) ? (63'd1 << p2) : 63'd0);
            run($sformatf("rand%0d", b), rx, cw, 1'b1);
        end
        check("no_ready_in_send", 64'(overlap), 64'd0);

        feed(cw0, 30, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_recv_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_recv_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run("after_rst_recv", cw0 ^ (63'd1 << 40), cw0, 1'b0);

        feed(cw0, 63, 1'b0);
        for (int t = 0; !out_valid && t < 300; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("mid_send_valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_send_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_send_out_data", {63'd0, out_data}, 64'd0);
        check("rst_send_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run("after_rst_send", cw0 ^ (63'd1 << 7) ^ (63'd1 << 33), cw0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
